// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Time-shares one combinational ALU between two requesters.
//             Round-robin grant per cycle, ALU operand/control muxing, and a
//             one-entry registered response slot per requester with a
//             valid/ready return handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    // Requester 0
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [DATA_W-1:0] req_in1_0,
    input  logic [DATA_W-1:0] req_in2_0,
    input  logic [CTL_W-1:0]  req_ctl_0,
    input  logic              req_sign_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    output logic [DATA_W-1:0] rsp_data_0,
    output logic              rsp_zero_0,

    // Requester 1
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_in1_1,
    input  logic [DATA_W-1:0] req_in2_1,
    input  logic [CTL_W-1:0]  req_ctl_1,
    input  logic              req_sign_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic              rsp_zero_1,

    // Shared combinational ALU
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTL_W-1:0]  alu_ctl,
    output logic              alu_sign,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

    localparam int c_NUM_REQ = 2;

    // ------------------------------------------------------------------
    // Per-requester views packed into vectors/arrays so the slot logic
    // below can be written once and iterated.
    // ------------------------------------------------------------------
    logic [c_NUM_REQ-1:0] w_req_valid;
    logic [c_NUM_REQ-1:0] w_rsp_ready;
    logic [c_NUM_REQ-1:0] w_free;
    logic [c_NUM_REQ-1:0] w_elig;
    logic [c_NUM_REQ-1:0] w_grant;

    logic [DATA_W-1:0]    w_in1  [c_NUM_REQ];
    logic [DATA_W-1:0]    w_in2  [c_NUM_REQ];
    logic [CTL_W-1:0]     w_ctl  [c_NUM_REQ];
    logic [c_NUM_REQ-1:0] w_sign;

    // Round-robin pointer: names the requester that wins a tie.
    logic                 r_prio;

    // Response slots.
    logic [c_NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data [c_NUM_REQ];
    logic [c_NUM_REQ-1:0] r_rsp_zero;

    assign w_req_valid = {req_valid_1, req_valid_0};
    assign w_rsp_ready = {rsp_ready_1, rsp_ready_0};
    assign w_sign      = {req_sign_1,  req_sign_0};

    assign w_in1[0] = req_in1_0;
    assign w_in1[1] = req_in1_1;
    assign w_in2[0] = req_in2_0;
    assign w_in2[1] = req_in2_1;
    assign w_ctl[0] = req_ctl_0;
    assign w_ctl[1] = req_ctl_1;

    // ------------------------------------------------------------------
    // Eligibility: a requester may only be granted when its response slot
    // is empty or is being drained in this very cycle, so a result is never
    // overwritten before the requester has taken it. A stuck slot only
    // blocks its own requester.
    // ------------------------------------------------------------------
    assign w_free = ~r_rsp_valid | w_rsp_ready;
    assign w_elig = w_req_valid & w_free;

    // ------------------------------------------------------------------
    // Round-robin grant. A lone eligible requester always wins; on a tie
    // the pointer decides. The two terms are mutually exclusive, so at most
    // one grant is issued per cycle.
    // ------------------------------------------------------------------
    assign w_grant[0] = w_elig[0] & (~w_elig[1] | ~r_prio);
    assign w_grant[1] = w_elig[1] & (~w_elig[0] |  r_prio);

    assign req_ready_0 = w_grant[0];
    assign req_ready_1 = w_grant[1];

    // Steer the granted requester's operation onto the ALU; idle drives zeros.
    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_ctl  = '0;
        alu_sign = 1'b0;
        if (w_grant[0]) begin
            alu_in1  = w_in1[0];
            alu_in2  = w_in2[0];
            alu_ctl  = w_ctl[0];
            alu_sign = w_sign[0];
        end else if (w_grant[1]) begin
            alu_in1  = w_in1[1];
            alu_in2  = w_in2[1];
            alu_ctl  = w_ctl[1];
            alu_sign = w_sign[1];
        end
    end

    // Pointer moves to the other requester after every grant, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_grant[0]) begin
            r_prio <= 1'b1;
        end else if (w_grant[1]) begin
            r_prio <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Response slots: a grant loads the ALU result (taking precedence over
    // a same-cycle drain so the slot stays valid), a drain alone clears the
    // valid flag while data/zero keep their last values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_zero  <= '0;
            for (int i = 0; i < c_NUM_REQ; i++) begin
                r_rsp_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= alu_out;
                    r_rsp_zero[i]  <= alu_zero;
                end else if (w_rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid_0 = r_rsp_valid[0];
    assign rsp_valid_1 = r_rsp_valid[1];
    assign rsp_data_0  = r_rsp_data[0];
    assign rsp_data_1  = r_rsp_data[1];
    assign rsp_zero_0  = r_rsp_zero[0];
    assign rsp_zero_1  = r_rsp_zero[1];

endmodule
`default_nettype wire
